mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single backing-memory port between the instruction-cache and data-cache miss paths of the 3-stage core.
- Accepts one line request at a time from either cache and arbitrates round-robin, dcache winning the first tie.
- Sequences the request phase, the write-data beats and the read-response beats, then routes responses back to the owning cache.
- Sits between the icache/dcache controllers and the memory model/DRAM interface.

Parameters:
ADDR_W, 32, request address width (byte address, passed through unmodified)
DATA_W, 128, width of one memory beat
LINE_BEATS, 4, beats per cache line (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ic_req_valid  in  1  icache line-read request
ic_req_ready  out  1  icache request accepted when valid&ready
ic_req_addr  in  ADDR_W  icache line address
ic_resp_valid  out  1  icache read beat valid
ic_resp_data  out  DATA_W  icache read beat
ic_resp_last  out  1  final beat of icache line
dc_req_valid  in  1  dcache request
dc_req_ready  out  1  dcache request accepted when valid&ready
dc_req_addr  in  ADDR_W  dcache line address
dc_req_rw  in  1  1=writeback, 0=refill
dc_wdata  in  DATA_W  current writeback beat
dc_wdata_ready  out  1  current dc_wdata beat consumed this cycle
dc_resp_valid  out  1  dcache read beat, or write-done pulse
dc_resp_data  out  DATA_W  dcache read beat (0 on write-done)
dc_resp_last  out  1  final beat / write-done
mem_req_valid  out  1  memory command valid
mem_req_ready  in  1  memory accepts command
mem_req_addr  out  ADDR_W  latched command address
mem_req_rw  out  1  latched command direction
mem_wdata_valid  out  1  write beat valid
mem_wdata_ready  in  1  memory accepts write beat
mem_wdata  out  DATA_W  write beat (= dc_wdata)
mem_resp_valid  in  1  read beat from memory
mem_resp_data  in  DATA_W  read beat data
busy  out  1  state != IDLE
owner  out  1  0=icache, 1=dcache, valid while busy

Behaviour:
- States: IDLE, CMD, WDATA, RDATA, WDONE.
- Reset (reset low, async): state=IDLE, beat counter=0, last_grant=icache, latched addr/rw/owner=0. All outputs 0, except mem_req_addr/mem_req_rw (latched values = 0) and mem_wdata (follows dc_wdata).
- Arbitration, IDLE only, combinational:
  - Only one valid: it wins.
  - Both valid: the winner is the requester that is not last_grant, so dcache wins the first tie after reset.
  - Only the winner's req_ready=1. Neither ready outside IDLE.
- On acceptance: latch addr, rw (0 for icache), owner; update last_grant; go to CMD the next cycle. Zero-cycle request-to-command latency is forbidden.
- CMD: mem_req_valid=1 with latched addr/rw, held stable until mem_req_ready. On handshake: rw=1 -> WDATA, rw=0 -> RDATA; counter cleared.
- WDATA:
  - mem_wdata_valid=1 and dc_wdata_ready=mem_wdata_ready, same cycle, combinational.
  - Each handshake increments the counter.
  - Handshake at count LINE_BEATS-1 -> WDONE.
  - The dcache must hold beat k on dc_wdata until dc_wdata_ready.
- WDONE: one cycle of dc_resp_valid=1, dc_resp_last=1, dc_resp_data=0; then IDLE.
- RDATA:
  - Each cycle with mem_resp_valid=1: that cycle, assert the owner's resp_valid and drive mem_resp_data (combinational pass-through); increment the counter.
  - resp_last=1 on beat LINE_BEATS-1, then IDLE next cycle.
  - Non-owner resp_valid stays 0.
- Counter is log2(LINE_BEATS) bits and wraps to 0 on the final beat.
- mem_resp_valid outside RDATA is ignored and never forwarded.
- A new request is accepted no earlier than the cycle after return to IDLE. Minimum back-to-back read occupancy = 2 + LINE_BEATS cycles.
- Request valids may drop before acceptance; no grant results.
- Reset asserted mid-transaction aborts immediately to the reset state. The in-flight transaction is lost; the memory side is reset in the same domain.

Test Plan:
- Reset, then ic_req_valid=1 addr 0x100; mem_req_ready=1; mem_resp_valid for 4 cycles with data 0xA..0xD -> ic_req_ready=1 in IDLE; CMD one cycle later with mem_req_addr 0x100, rw=0; ic_resp_valid x4, last only on 0xD; busy low after.
- ic and dc both valid in IDLE after reset -> dc granted first (owner=1), ic granted on the next IDLE; with both held continuously, grants alternate dc, ic, dc.
- dc writeback addr 0x2000, beats 0x1..0x4, mem_wdata_ready toggling 1,0,1,0,... -> each beat held until accepted; exactly 4 dc_wdata_ready pulses; one WDONE pulse with dc_resp_last=1, data 0.
- mem_req_ready held 0 for 5 cycles in CMD -> mem_req_valid/addr stable for all 5; no state advance.
- Spurious mem_resp_valid in IDLE and CMD -> no ic/dc resp_valid; beat counter unchanged.
- Reset low during RDATA after 2 beats -> all outputs 0 at once; next read returns a full 4 beats with last on beat 4.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between the icache and dcache
// miss paths: request phase, write-data beats, read-response beats, response routing.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 128,
    parameter int LINE_BEATS = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    output logic              ic_resp_last,

    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_rw,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              dc_resp_last,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_rw,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,

    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = $clog2(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        WDONE
    } state_e;

    // Latched command; owner encoding matches last_grant: 0=icache, 1=dcache.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic              owner;
    } cmd_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    cmd_t             cmd_q, cmd_d;

    logic idle;
    logic grant_dc;
    logic grant_ic;
    logic final_beat;
    logic rd_fire;
    logic wr_fire;

    always_comb begin
        idle       = (state_q == IDLE);
        // On a tie the requester that did not win last time goes first.
        grant_dc   = dc_req_valid && (!ic_req_valid || !last_grant_q);
        grant_ic   = ic_req_valid && !grant_dc;
        final_beat = (cnt_q == LAST_BEAT);
        rd_fire    = (state_q == RDATA) && mem_resp_valid;
        wr_fire    = (state_q == WDATA) && mem_wdata_ready;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dc || grant_ic) begin
                    cmd_d.addr   = grant_dc ? dc_req_addr : ic_req_addr;
                    cmd_d.rw     = grant_dc && dc_req_rw;
                    cmd_d.owner  = grant_dc;
                    last_grant_d = grant_dc;
                    state_d      = CMD;
                end
            end
            CMD: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = cmd_q.rw ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (wr_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (final_beat) state_d = WDONE;
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            RDATA: begin
                if (rd_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (final_beat) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b0;
            cmd_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
        end
    end

    // Ready is gated by reset so every handshake output reads 0 while reset is held.
    assign ic_req_ready    = reset && idle && grant_ic;
    assign dc_req_ready    = reset && idle && grant_dc;

    assign mem_req_valid   = (state_q == CMD);
    assign mem_req_addr    = cmd_q.addr;
    assign mem_req_rw      = cmd_q.rw;
    assign mem_wdata_valid = (state_q == WDATA);
    assign mem_wdata       = dc_wdata;
    assign dc_wdata_ready  = wr_fire;

    assign ic_resp_valid   = rd_fire && !cmd_q.owner;
    assign ic_resp_data    = ic_resp_valid ? mem_resp_data : '0;
    assign ic_resp_last    = ic_resp_valid && final_beat;

    assign dc_resp_valid   = (rd_fire && cmd_q.owner) || (state_q == WDONE);
    assign dc_resp_data    = (rd_fire && cmd_q.owner) ? mem_resp_data : '0;
    assign dc_resp_last    = (rd_fire && cmd_q.owner && final_beat) || (state_q == WDONE);

    assign busy            = !idle;
    assign owner           = cmd_q.owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants, commands,
// write beats and responses; a monitor compares at each falling edge.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int LB     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req_valid, ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid, ic_resp_last;
    logic [DATA_W-1:0] ic_resp_data;
    logic              dc_req_valid, dc_req_ready, dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_wdata, dc_resp_data;
    logic              dc_wdata_ready, dc_resp_valid, dc_resp_last;
    logic              mem_req_valid, mem_req_ready, mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wdata_valid, mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata, mem_resp_data;
    logic              mem_resp_valid;
    logic              busy, owner;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BEATS(LB)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_wdata(dc_wdata), .dc_wdata_ready(dc_wdata_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_last(dc_resp_last),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner)
    );

    typedef struct {
        logic              dc;
        logic [DATA_W-1:0] data;
        logic              last;
    } rsp_t;

    rsp_t rsp_q[$];
    bit   grant_log[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction-level model state, written only by the monitor.
    bit                m_last, cmd_active, reading, writing, wdone_due;
    logic [ADDR_W-1:0] cur_addr;
    bit                cur_rw;
    int                rd_beat, wr_beat, wpulse_cnt, wdone_cnt;

    // Memory-side knobs, written only by the main sequence.
    int unsigned req_pct = 100, wr_pct = 100, rsp_pct = 100;
    bit          spur_en = 1'b0, wr_toggle = 1'b0;

    function automatic logic [DATA_W-1:0] rd_pat(logic [ADDR_W-1:0] a, int k);
        return {a, 32'(k), ~a, 32'hA5A5_0000 | 32'(k)};
    endfunction

    function automatic logic [DATA_W-1:0] wd_pat(logic [ADDR_W-1:0] a, int k);
        return {~a, 32'hC0DE_0000 | 32'(k), a, 32'(k * 3 + 1)};
    endfunction

    task automatic chk1(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out t=%0t", nm, $time);
    endtask

    // Memory model: drives ready/response inputs just after each rising edge.
    initial begin
        bit tog;
        tog = 1'b0;
        mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        forever begin
            @(posedge clk); #1;
            tog             = !tog;
            mem_req_ready   = ($urandom_range(99) < req_pct);
            mem_wdata_ready = wr_toggle ? tog : ($urandom_range(99) < wr_pct);
            if (reading) begin
                mem_resp_valid = ($urandom_range(99) < rsp_pct);
                mem_resp_data  = rd_pat(cur_addr, rd_beat);
            end else begin
                mem_resp_valid = spur_en && ($urandom_range(1) == 1);
                mem_resp_data  = {4{$urandom()}};
            end
        end
    end

    // Monitor: predicts every cycle from the model, compares, then advances the model.
    initial begin
        bit   n_cmd, n_rd, n_wr, n_wd, exp_dc, exp_resp, mbusy;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cmd_active = 0; reading = 0; writing = 0; wdone_due = 0;
                m_last = 0; rd_beat = 0; wr_beat = 0;
                rsp_q.delete();
                continue;
            end
            n_cmd = cmd_active; n_rd = reading; n_wr = writing; n_wd = 0;
            mbusy = cmd_active || reading || writing || wdone_due;
            chk1("busy", busy, mbusy);

            if (!mbusy) begin
                exp_dc = dc_req_valid && (!ic_req_valid || !m_last);
                chk1("ic_req_ready", ic_req_ready, ic_req_valid && !exp_dc);
                chk1("dc_req_ready", dc_req_ready, exp_dc);
                if (ic_req_valid || dc_req_valid) begin
                    m_last   = exp_dc;
                    grant_log.push_back(exp_dc);
                    cur_addr = exp_dc ? dc_req_addr : ic_req_addr;
                    cur_rw   = exp_dc && dc_req_rw;
                    n_cmd    = 1;
                    if (cur_rw) begin
                        e.dc = 1; e.data = '0; e.last = 1;
                        rsp_q.push_back(e);
                    end else begin
                        for (int k = 0; k < LB; k++) begin
                            e.dc = exp_dc; e.data = rd_pat(cur_addr, k); e.last = (k == LB - 1);
                            rsp_q.push_back(e);
                        end
                    end
                end
            end else begin
                chk1("ic_req_ready_busy", ic_req_ready, 1'b0);
                chk1("dc_req_ready_busy", dc_req_ready, 1'b0);
            end

            chk1("mem_req_valid", mem_req_valid, cmd_active);
            if (cmd_active) begin
                chkw("mem_req_addr", DATA_W'(mem_req_addr), DATA_W'(cur_addr));
                chk1("mem_req_rw", mem_req_rw, cur_rw);
                if (mem_req_ready) begin
                    n_cmd = 0;
                    if (cur_rw) begin n_wr = 1; wr_beat = 0; end
                    else begin n_rd = 1; rd_beat = 0; end
                end
            end

            chk1("mem_wdata_valid", mem_wdata_valid, writing);
            chk1("dc_wdata_ready", dc_wdata_ready, writing && mem_wdata_ready);
            if (dc_wdata_ready) wpulse_cnt++;
            if (writing && mem_wdata_ready) begin
                chkw("mem_wdata", mem_wdata, wd_pat(cur_addr, wr_beat));
                wr_beat++;
                if (wr_beat == LB) begin n_wr = 0; n_wd = 1; end
            end

            exp_resp = (reading && mem_resp_valid) || wdone_due;
            chk1("resp_valid_any", ic_resp_valid || dc_resp_valid, exp_resp);
            if (wdone_due && dc_resp_valid) wdone_cnt++;
            if (exp_resp && (ic_resp_valid || dc_resp_valid)) begin
                if (rsp_q.size() == 0) begin
                    timeout("resp_q_underflow");
                end else begin
                    e = rsp_q.pop_front();
                    chk1("resp_owner_dc", dc_resp_valid, e.dc);
                    chk1("resp_owner_ic", ic_resp_valid, !e.dc);
                    chkw("resp_data", e.dc ? dc_resp_data : ic_resp_data, e.data);
                    chk1("resp_last", e.dc ? dc_resp_last : ic_resp_last, e.last);
                end
            end
            if (reading && mem_resp_valid) begin
                rd_beat++;
                if (rd_beat == LB) n_rd = 0;
            end
            cmd_active = n_cmd; reading = n_rd; writing = n_wr; wdone_due = n_wd;
        end
    end

    task automatic ic_req(input logic [ADDR_W-1:0] a);
        @(posedge clk); #1;
        ic_req_valid = 1'b1; ic_req_addr = a;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (ic_req_ready) begin
                @(posedge clk); #1;
                ic_req_valid = 1'b0; ic_req_addr = $urandom();
                return;
            end
        end
        timeout("ic_req_accept");
        ic_req_valid = 1'b0;
    endtask

    task automatic dc_req(input logic [ADDR_W-1:0] a, input logic rw);
        int k;
        bit acc;
        acc = 0;
        @(posedge clk); #1;
        dc_req_valid = 1'b1; dc_req_addr = a; dc_req_rw = rw; dc_wdata = wd_pat(a, 0);
        for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = dc_req_ready;
        end
        @(posedge clk); #1;
        dc_req_valid = 1'b0; dc_req_addr = $urandom();
        if (!acc) begin timeout("dc_req_accept"); return; end
        if (!rw) return;
        k = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (dc_wdata_ready) k++;
            @(posedge clk); #1;
            if (k == LB) begin dc_wdata = {4{$urandom()}}; return; end
            dc_wdata = wd_pat(a, k);
        end
        timeout("dc_wdata_beats");
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 1000; t++) begin
            @(posedge clk); #2;
            if (!busy && !cmd_active && !reading && !writing && !wdone_due && rsp_q.size() == 0) return;
        end
        timeout("wait_idle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, p0, w0, g0, kind;
        bit hit;
        logic [ADDR_W-1:0] a, b;

        reset = 1'b0; spur_en = 1'b1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h100;
        dc_req_valid = 1'b1; dc_req_addr = 32'h2000; dc_req_rw = 1'b1; dc_wdata = {4{$urandom()}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_ic_req_ready", ic_req_ready, 1'b0);
        chk1("rst_dc_req_ready", dc_req_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chkw("rst_mem_req_addr", DATA_W'(mem_req_addr), '0);
        chk1("rst_mem_req_rw", mem_req_rw, 1'b0);
        chk1("rst_mem_wdata_valid", mem_wdata_valid, 1'b0);
        chk1("rst_dc_wdata_ready", dc_wdata_ready, 1'b0);
        chk1("rst_ic_resp_valid", ic_resp_valid, 1'b0);
        chk1("rst_dc_resp_valid", dc_resp_valid, 1'b0);
        chkw("rst_ic_resp_data", ic_resp_data, '0);
        chkw("rst_dc_resp_data", dc_resp_data, '0);
        chkw("rst_mem_wdata", mem_wdata, dc_wdata);
        @(posedge clk); #1;
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_req_rw = 1'b0;
        #1; reset = 1'b1; spur_en = 1'b0;

        // single icache refill
        ic_req(32'h100);
        wait_idle();

        // simultaneous requests held: dc, ic, dc
        n0 = grant_log.size();
        fork
            begin dc_req(32'h1000, 1'b0); dc_req(32'h1040, 1'b0); end
            ic_req(32'h200);
        join
        wait_idle();
        chkw("tie_grant_count", DATA_W'(grant_log.size()), DATA_W'(n0 + 3));
        if (grant_log.size() >= n0 + 3) begin
            chk1("tie_grant0_dc", grant_log[n0], 1'b1);
            chk1("tie_grant1_ic", grant_log[n0 + 1], 1'b0);
            chk1("tie_grant2_dc", grant_log[n0 + 2], 1'b1);
        end

        // writeback with toggling write ready
        wr_toggle = 1'b1;
        p0 = wpulse_cnt; w0 = wdone_cnt;
        dc_req(32'h2000, 1'b1);
        wait_idle();
        chkw("wb_ready_pulses", DATA_W'(wpulse_cnt - p0), DATA_W'(LB));
        chkw("wb_done_pulses", DATA_W'(wdone_cnt - w0), DATA_W'(1));
        wr_toggle = 1'b0;

        // command stall with spurious responses and an abandoned dc request
        req_pct = 0; spur_en = 1'b1;
        g0 = grant_log.size();
        ic_req(32'h300);
        dc_req_valid = 1'b1; dc_req_addr = 32'h3300; dc_req_rw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("stall_mem_req_valid", mem_req_valid, 1'b1);
            chkw("stall_mem_req_addr", DATA_W'(mem_req_addr), DATA_W'(32'h300));
        end
        @(posedge clk); #1;
        dc_req_valid = 1'b0;
        #1; req_pct = 100;
        wait_idle();
        repeat (6) @(posedge clk);
        #2;
        chkw("stall_grants", DATA_W'(grant_log.size()), DATA_W'(g0 + 1));
        spur_en = 1'b0;

        // reset in the middle of a refill
        rsp_pct = 100;
        ic_req(32'h400);
        hit = 0;
        for (int t = 0; t < 50 && !hit; t++) begin
            @(posedge clk); #2;
            hit = reading && (rd_beat == 2);
        end
        if (!hit) timeout("mid_read_beat2");
        reset = 1'b0;
        #1;
        chk1("midrst_ic_resp_valid", ic_resp_valid, 1'b0);
        chkw("midrst_ic_resp_data", ic_resp_data, '0);
        chk1("midrst_ic_resp_last", ic_resp_last, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_mem_req_valid", mem_req_valid, 1'b0);
        chkw("midrst_mem_req_addr", DATA_W'(mem_req_addr), '0);
        repeat (2) @(posedge clk);
        #2; reset = 1'b1;
        ic_req(32'h500);
        wait_idle();

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            req_pct = $urandom_range(100, 20);
            wr_pct  = $urandom_range(100, 20);
            rsp_pct = $urandom_range(100, 20);
            spur_en = ($urandom_range(1) == 1);
            kind    = $urandom_range(3);
            a = $urandom() & 32'hFFFF_FFC0;
            b = $urandom() & 32'hFFFF_FFC0;
            case (kind)
                0: ic_req(a);
                1: dc_req(a, 1'b0);
                2: dc_req(a, 1'b1);
                default: fork
                    ic_req(a);
                    dc_req(b, ($urandom_range(1) == 1));
                join
            endcase
            wait_idle();
        end

        chkw("rsp_q_drained", DATA_W'(rsp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
